// File: rtl/conv_bin_bcd_pkg.sv
// Shared sizing helpers and seven-segment table for the binary-to-BCD converter.
package conv_bin_bcd_pkg;

    // Segment patterns {g,f,e,d,c,b,a}, active high, for decimal digits 0..9.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    // Number of decimal digits needed to show 2^bin_w - 1.
    function automatic int unsigned bcd_digits(input int unsigned bin_w);
        longint unsigned max_v;
        int unsigned     n;
        max_v = (64'd1 << bin_w) - 64'd1;
        n     = 1;
        for (int unsigned i = 0; i < 20; i++) begin
            if (max_v >= 64'd10) begin
                max_v = max_v / 64'd10;
                n     = n + 1;
            end
        end
        return n;
    endfunction

    // Minimum packed BCD width: full 4-bit lower digits plus just enough
    // bits for the largest value the top digit can take.
    function automatic int unsigned bcd_bits(input int unsigned bin_w);
        longint unsigned max_v;
        int unsigned     top_bits;
        max_v = (64'd1 << bin_w) - 64'd1;
        for (int unsigned i = 0; i < 20; i++) begin
            if (max_v >= 64'd10) begin
                max_v = max_v / 64'd10;
            end
        end
        if (max_v < 64'd2)      top_bits = 1;
        else if (max_v < 64'd4) top_bits = 2;
        else if (max_v < 64'd8) top_bits = 3;
        else                    top_bits = 4;
        return 4 * (bcd_digits(bin_w) - 1) + top_bits;
    endfunction

    // Segment pattern for one BCD digit; non-decimal codes blank the digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        return (digit <= 4'd9) ? SEG_TABLE[digit] : 7'b0000000;
    endfunction

endpackage

// File: rtl/conv_bin_bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add-3 correction so the following shift carries correctly into the next digit.
    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/conv_bin_bcd.sv
// Registered binary-to-BCD converter (combinational double dabble, 1-cycle latency).
// Optional seven-segment output enabled by defining CONV_BIN_BCD_SEG_EN.
module conv_bin_bcd
    import conv_bin_bcd_pkg::*;
#(
    parameter int unsigned BIN_W = 4,
    parameter int unsigned P_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [BIN_W-1:0] b,
    output logic             out_valid,
    output logic [P_W-1:0]   p
`ifdef CONV_BIN_BCD_SEG_EN
    ,
    output logic [7*bcd_digits(BIN_W)-1:0] seg
`endif
);

    localparam int unsigned DIGITS = bcd_digits(BIN_W);
    localparam int unsigned SW     = 4 * DIGITS;

    if (BIN_W < 1 || BIN_W > 16) begin : g_bad_bin_w
        $error("conv_bin_bcd: BIN_W=%0d outside 1..16", BIN_W);
    end
    if (P_W < bcd_bits(BIN_W)) begin : g_bad_p_w
        $error("conv_bin_bcd: P_W=%0d too small, need %0d", P_W, bcd_bits(BIN_W));
    end

    // stage[i] is the BCD scratch after i shifts; adj[i] is stage[i] after add-3.
    logic [BIN_W:0][SW-1:0]   stage;
    logic [BIN_W-1:0][SW-1:0] adj;
    logic [BIN_W-1:0]         unused_msb;
    logic [SW-1:0]            fin;
    logic [P_W-1:0]           conv;

    assign stage[0] = '0;

    for (genvar i = 0; i < BIN_W; i++) begin : g_iter
        for (genvar d = 0; d < DIGITS; d++) begin : g_dig
            bcd_add3 u_add3 (
                .din  (stage[i][4*d +: 4]),
                .dout (adj[i][4*d +: 4])
            );
        end
        // Top bit shifted out is always 0 since DIGITS covers the full range.
        assign stage[i+1]    = {adj[i][SW-2:0], b[BIN_W-1-i]};
        assign unused_msb[i] = adj[i][SW-1];
    end

    assign fin = stage[BIN_W];

    // Fit the scratch to P_W: zero-fill surplus bits or truncate the top digit.
    if (P_W >= SW) begin : g_fill
        assign conv = P_W'(fin);
    end else begin : g_trunc
        logic [SW-P_W-1:0] unused_hi;
        assign conv      = fin[P_W-1:0];
        assign unused_hi = fin[SW-1:P_W];
    end

    logic           out_valid_q, out_valid_d;
    logic [P_W-1:0] p_q, p_d;

    // Capture a new result on accepted input, otherwise hold the last one.
    always_comb begin
        out_valid_d = in_valid;
        p_d         = in_valid ? conv : p_q;
    end

    // Output registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p         = p_q;

`ifdef CONV_BIN_BCD_SEG_EN
    logic [7*DIGITS-1:0] seg_conv, seg_q, seg_d;

    // Decode every digit of the full scratch so a truncated top digit still displays.
    always_comb begin
        seg_conv = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            seg_conv[7*d +: 7] = seg_encode(fin[4*d +: 4]);
        end
        seg_d = in_valid ? seg_conv : seg_q;
    end

    // Segment register moves in lockstep with p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_conv_bin_bcd.sv
// Directed scoreboard bench for conv_bin_bcd (default BIN_W=4, P_W=5).
module tb_conv_bin_bcd;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] b;
    logic       out_valid;
    logic [4:0] p;
`ifdef CONV_BIN_BCD_SEG_EN
    logic [13:0] seg;
    logic [31:0] sb_seg[$];
    logic [31:0] last_seg;
`endif

    int          checks;
    int          errors;
    logic [31:0] sb_p[$];
    logic [31:0] last_p;

    conv_bin_bcd #(
        .BIN_W (4),
        .P_W   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .b         (b),
        .out_valid (out_valid),
        .p         (p)
`ifdef CONV_BIN_BCD_SEG_EN
        ,
        .seg       (seg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bcd_model(input int v);
        return 32'((v / 10) * 16 + (v % 10));
    endfunction

`ifdef CONV_BIN_BCD_SEG_EN
    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [31:0] seg_model(input int v);
        return {18'd0, seg7(v / 10), seg7(v % 10)};
    endfunction
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare outputs against the scoreboard head, or against the held value when idle.
    task automatic check_out(input string tag);
        logic [31:0] e;
        if (sb_p.size() > 0) begin
            e = sb_p.pop_front();
            chk({tag, "_p"}, 32'(p), e);
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            last_p = e;
`ifdef CONV_BIN_BCD_SEG_EN
            e = sb_seg.pop_front();
            chk({tag, "_seg"}, 32'(seg), e);
            last_seg = e;
`endif
        end else begin
            chk({tag, "_hold_p"}, 32'(p), last_p);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd0);
`ifdef CONV_BIN_BCD_SEG_EN
            chk({tag, "_hold_seg"}, 32'(seg), last_seg);
`endif
        end
    endtask

    // Drive one cycle of stimulus at a negedge, sample after the next posedge.
    task automatic drive(input string tag, input logic v, input int bv);
        in_valid = v;
        b        = 4'(bv);
        if (v) begin
            sb_p.push_back(bcd_model(bv));
`ifdef CONV_BIN_BCD_SEG_EN
            sb_seg.push_back(seg_model(bv));
`endif
        end
        @(posedge clk);
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic clear_model();
        sb_p.delete();
        last_p = '0;
`ifdef CONV_BIN_BCD_SEG_EN
        sb_seg.delete();
        last_seg = '0;
`endif
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        b        = 4'd9;
        clear_model();

        // Reset held with valid input present: outputs stay cleared.
        @(negedge clk);
        chk("rst_p", 32'(p), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_out("rst_hold");

        // Release; first edge converts b=9.
        rst_n = 1'b1;
        drive("release_b9", 1'b1, 9);

        // Boundary values back to back.
        drive("bnd_b9", 1'b1, 9);
        drive("bnd_b10", 1'b1, 10);
        drive("bnd_b15", 1'b1, 15);

        // Ramp 0..15 and wrap to 0.
        for (int i = 0; i <= 16; i++) begin
            drive($sformatf("ramp_%0d", i), 1'b1, i % 16);
        end

        // Idle after b=12: p holds 1_0010 while b changes.
        drive("pre_idle_b12", 1'b1, 12);
        drive("idle_b3", 1'b0, 3);
        chk("idle_p_const", 32'(p), 32'h12);
        drive("idle_b3_again", 1'b0, 3);

        // Reset pulse mid-ramp with b=7 pending: outputs clear at once, b=7 discarded.
        drive("mid_b5", 1'b1, 5);
        drive("mid_b6", 1'b1, 6);
        in_valid = 1'b1;
        b        = 4'd7;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_p", 32'(p), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        clear_model();
        @(posedge clk);
        @(negedge clk);
        check_out("rst_mid_hold");
        rst_n = 1'b1;
        drive("after_rst_b8", 1'b1, 8);

        // Two-digit value exercising the seven-segment decode when enabled.
        drive("b13", 1'b1, 13);
        chk("b13_p_const", 32'(p), 32'h13);
        drive("b13_idle", 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
